// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default width/depth, zero-register index.
package rf_pkg;

   typedef enum logic {
      RF_INIT  = 1'b0,
      RF_READY = 1'b1
   } rf_state_e;

   localparam int RF_XLEN_DEF  = 32;
   localparam int RF_NREGS_DEF = 32;
   localparam int RF_ZERO_REG  = 0;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps every register to zero after reset or on clr request.
// Latency: NREGS cycles of sweep; ready rises the cycle after the last sweep edge.
// Backpressure: none; while ready is low the array owns all write bandwidth.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clr         - restart the sweep (from READY or mid-sweep)
//   ready       - registered, high once the array holds valid contents
//   sweep_we    - zero-write enable toward the array
//   sweep_addr  - register being zeroed this cycle
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter  int NREGS = RF_NREGS_DEF,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          ready,
   output logic          sweep_we,
   output logic [AW-1:0] sweep_addr
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   rf_state_e     state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RF_INIT;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sweep_we  = 1'b0;
      case (state)
         RF_INIT: begin
            sweep_we = 1'b1;
            // A clear during the sweep restarts it so the full NREGS
            // cycles are counted from the last clr cycle.
            if (clr) begin
               cnt_nxt = '0;
            end else if (cnt == LAST) begin
               state_nxt = RF_READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RF_READY: begin
            if (clr) begin
               state_nxt = RF_INIT;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = RF_INIT;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign sweep_addr = cnt;
   assign ready      = (state == RF_READY);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with zero-sweep sequencer and busy scoreboard.
// Latency: combinational reads; writes/issues visible to plain reads next cycle.
// Backpressure: none; writes and issues presented while ready_o=0 are dropped.
//
// Ports: clk, rst_n (async active-low); clr_i sweep request; ready_o array valid;
//   we_i/waddr_i/wdata_i write ports (port p at [p*W +: W]); raddr_i/rdata_o/busy_o
//   read ports; iss_valid_i/iss_rd_i mark a destination register busy.
// Build option: RF_BYPASS_EN forwards same-cycle writes (and issue busy) to reads.
module regfile_mp
   import rf_pkg::*;
#(
   parameter  int XLEN  = RF_XLEN_DEF,
   parameter  int NREGS = RF_NREGS_DEF,
   parameter  int NRD   = 2,
   parameter  int NWR   = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr_i,
   output logic                ready_o,
   input  logic [NWR-1:0]      we_i,
   input  logic [NWR*AW-1:0]   waddr_i,
   input  logic [NWR*XLEN-1:0] wdata_i,
   input  logic [NRD*AW-1:0]   raddr_i,
   output logic [NRD*XLEN-1:0] rdata_o,
   output logic [NRD-1:0]      busy_o,
   input  logic                iss_valid_i,
   input  logic [AW-1:0]       iss_rd_i
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(RF_ZERO_REG);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy, busy_nxt;
   logic             sweep_we;
   logic [AW-1:0]    sweep_addr;
   logic [NWR-1:0]   wr_act;

   rf_clear_seq #(.NREGS(NREGS)) u_clear_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr_i),
      .ready      (ready_o),
      .sweep_we   (sweep_we),
      .sweep_addr (sweep_addr)
   );

   // A write port only counts once the array is valid and it targets x1..
   always_comb begin
      for (int p = 0; p < NWR; p++) begin
         wr_act[p] = ready_o && we_i[p] && (waddr_i[p*AW +: AW] != ZERO_IDX);
      end
   end

   // Storage has no reset: the sweep defines contents. Sweep and port writes
   // are mutually exclusive (sweep only in INIT, ports only in READY); the
   // highest port is assigned last so it wins on an address collision.
   always_ff @(posedge clk) begin
      if (sweep_we) begin
         regs[sweep_addr] <= '0;
      end
      for (int p = 0; p < NWR; p++) begin
         if (wr_act[p]) begin
            regs[waddr_i[p*AW +: AW]] <= wdata_i[p*XLEN +: XLEN];
         end
      end
   end

   // Writes clear busy first, then an issue sets it: a new producer outranks
   // the retiring one.
   always_comb begin
      busy_nxt = busy;
      for (int p = 0; p < NWR; p++) begin
         if (wr_act[p]) begin
            busy_nxt[waddr_i[p*AW +: AW]] = 1'b0;
         end
      end
      if (ready_o && iss_valid_i) begin
         busy_nxt[iss_rd_i] = 1'b1;
      end
      busy_nxt[ZERO_IDX] = 1'b0;
      if (!ready_o || clr_i) begin
         busy_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

   // Reads return zero while sweeping and for x0.
   always_comb begin
      rdata_o = '0;
      busy_o  = '0;
      for (int p = 0; p < NRD; p++) begin
         if (ready_o && (raddr_i[p*AW +: AW] != ZERO_IDX)) begin
            rdata_o[p*XLEN +: XLEN] = regs[raddr_i[p*AW +: AW]];
            busy_o[p]               = busy[raddr_i[p*AW +: AW]];
`ifdef RF_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
               if (wr_act[w] && (waddr_i[w*AW +: AW] == raddr_i[p*AW +: AW])) begin
                  rdata_o[p*XLEN +: XLEN] = wdata_i[w*XLEN +: XLEN];
                  busy_o[p]               = 1'b0;
               end
            end
            if (iss_valid_i && (iss_rd_i == raddr_i[p*AW +: AW])) begin
               busy_o[p] = 1'b1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (XLEN=32, NREGS=32, NRD=2, NWR=2).
module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clr_i = 1'b0;
   logic                ready_o;
   logic [NWR-1:0]      we_i = '0;
   logic [NWR*AW-1:0]   waddr_i = '0;
   logic [NWR*XLEN-1:0] wdata_i = '0;
   logic [NRD*AW-1:0]   raddr_i = '0;
   logic [NRD*XLEN-1:0] rdata_o;
   logic [NRD-1:0]      busy_o;
   logic                iss_valid_i = 1'b0;
   logic [AW-1:0]       iss_rd_i = '0;

   int vecs = 0;
   int miss = 0;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr_i),
      .ready_o     (ready_o),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .raddr_i     (raddr_i),
      .rdata_o     (rdata_o),
      .busy_o      (busy_o),
      .iss_valid_i (iss_valid_i),
      .iss_rd_i    (iss_rd_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we_i        = '0;
      iss_valid_i = 1'b0;
      clr_i       = 1'b0;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
      we_i[p]                 = 1'b1;
      waddr_i[p*AW +: AW]     = a;
      wdata_i[p*XLEN +: XLEN] = d;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      raddr_i[p*AW +: AW] = a;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      iss_valid_i = 1'b1;
      iss_rd_i    = a;
   endtask

   function automatic logic [31:0] rdat(input int p);
      return rdata_o[p*XLEN +: XLEN];
   endfunction

   task automatic wait_ready(input string tag, input int exp);
      int n = 0;
      while (!ready_o && n < 100) begin
         step();
         n++;
      end
      chk(tag, n, exp);
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < NREGS; a++) begin
         rd(0, a[AW-1:0]);
         rd(1, 5'(NREGS - 1 - a));
         #1;
         chk({tag, "_rd0"}, rdat(0), 32'h0);
         chk({tag, "_rd1"}, rdat(1), 32'h0);
         chk({tag, "_busy"}, {30'b0, busy_o}, 32'h0);
      end
   endtask

   initial begin
      int n;
      // Reset state
      #1;
      chk("rst_ready", ready_o, 1'b0);
      chk("rst_rdata", rdata_o[31:0], 32'h0);
      chk("rst_busy", {30'b0, busy_o}, 32'h0);
      step();
      step();
      rst_n = 1'b1;
      wait_ready("sweep_len", 32);

      // Reset pulse mid-sweep restarts the full sweep
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("mid_ready", ready_o, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_ready", ready_o, 1'b0);
      rst_n = 1'b1;
      wait_ready("resweep_len", 32);
      check_all_zero("post_sweep");

      // Write then read
      step();
      wr(0, 5'd5, 32'hDEADBEEF);
      step();
      idle();
      rd(0, 5'd5);
      rd(1, 5'd5);
      #2;
      chk("x5_p0", rdat(0), 32'hDEADBEEF);
      chk("x5_p1", rdat(1), 32'hDEADBEEF);

      wr(1, 5'd0, 32'h1234);
      rd(0, 5'd0);
      step();
      idle();
      #2;
      chk("x0_rd", rdat(0), 32'h0);
      chk("x0_busy", busy_o[0], 1'b0);

      // Dual-write conflict and independent dual writes
      wr(0, 5'd7, 32'h1);
      wr(1, 5'd7, 32'h2);
      step();
      idle();
      rd(0, 5'd7);
      #2;
      chk("x7_conflict", rdat(0), 32'h2);

      wr(0, 5'd10, 32'h11);
      wr(1, 5'd11, 32'h22);
      step();
      idle();
      rd(0, 5'd10);
      rd(1, 5'd11);
      #2;
      chk("x10_dual", rdat(0), 32'h11);
      chk("x11_dual", rdat(1), 32'h22);

      // Scoreboard
      iss(5'd9);
      step();
      idle();
      rd(0, 5'd9);
      rd(1, 5'd10);
      #2;
      chk("x9_busy", busy_o[0], 1'b1);
      chk("x10_notbusy", busy_o[1], 1'b0);

      iss(5'd9);
      wr(0, 5'd9, 32'h99);
      step();
      idle();
      #2;
      chk("x9_set_wins", busy_o[0], 1'b1);
      chk("x9_data", rdat(0), 32'h99);

      wr(1, 5'd9, 32'h98);
      step();
      idle();
      #2;
      chk("x9_cleared", busy_o[0], 1'b0);
      chk("x9_data2", rdat(0), 32'h98);

      iss(5'd0);
      step();
      idle();
      rd(0, 5'd0);
      #2;
      chk("x0_never_busy", busy_o[0], 1'b0);

      // Same-cycle write/read of x3 (x3 busy beforehand)
      iss(5'd3);
      step();
      idle();
      wr(0, 5'd3, 32'hAA);
      rd(0, 5'd3);
      #2;
`ifdef RF_BYPASS_EN
      chk("byp_data", rdat(0), 32'hAA);
      chk("byp_busy", busy_o[0], 1'b0);
`else
      chk("nobyp_data", rdat(0), 32'h0);
      chk("nobyp_busy", busy_o[0], 1'b1);
`endif
      step();
      idle();
      #2;
      chk("x3_after", rdat(0), 32'hAA);
      chk("x3_busy_after", busy_o[0], 1'b0);

      wr(0, 5'd3, 32'hBB);
      wr(1, 5'd3, 32'hCC);
      #2;
`ifdef RF_BYPASS_EN
      chk("byp_hiport", rdat(0), 32'hCC);
`else
      chk("nobyp_hiport", rdat(0), 32'hAA);
`endif
      step();
      idle();
      #2;
      chk("x3_hiport_after", rdat(0), 32'hCC);

      // Fill, then clear request
      for (int a = 1; a < NREGS; a++) begin
         wr(0, a[AW-1:0], a * 32'h01010101);
         step();
         idle();
      end
      iss(5'd4);
      step();
      idle();
      rd(0, 5'd31);
      rd(1, 5'd4);
      #2;
      chk("fill_x31", rdat(0), 32'h1F1F1F1F);
      chk("fill_x4_busy", busy_o[1], 1'b1);

      clr_i = 1'b1;
      step();
      idle();
      #1;
      chk("clr_ready", ready_o, 1'b0);
      n = 0;
      while (!ready_o && n < 100) begin
         if (n == 3) begin
            rd(0, 5'd31);
            #1;
            chk("init_rd_zero", rdat(0), 32'h0);
         end
         if (n == 5) begin
            wr(0, 5'd2, 32'h55);
            iss(5'd6);
         end
         step();
         idle();
         n++;
      end
      chk("clr_sweep_len", n, 32);
      check_all_zero("post_clr");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, successor to the single-write, dual-read register file. Adds configurable width, depth, and read/write port count. Also adds a hardware clear sequencer that sweeps the array to zero after reset or on request, and a per-register busy scoreboard for issue hazard checks. Sits between decode/issue (read ports, scoreboard) and writeback (write ports).

## Interface
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, ≥ 2.
- `NRD`, 2, read ports, 1..4.
- `NWR`, 1, write ports, 1..2.
- `AW`, $clog2(NREGS), address width (derived, not overridden).
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr_i`  in  1  request a full array clear sweep.
- `ready_o`  out  1  array valid; writes and issues accepted.
- `we_i`  in  NWR  write enable per port.
- `waddr_i`  in  NWR*AW  write address, port p at [p*AW +: AW].
- `wdata_i`  in  NWR*XLEN  write data per port.
- `raddr_i`  in  NRD*AW  read address per port.
- `rdata_o`  out  NRD*XLEN  read data per port.
- `busy_o`  out  NRD  scoreboard bit of `raddr_i` per port.
- `iss_valid_i`  in  1  issue of an instruction with a destination.
- `iss_rd_i`  in  AW  destination register being issued.

## Operation
- **Register 0.** Reads 0 and is never busy. Writes and issues targeting 0 are discarded.
- **FSM states.** INIT and READY.
  - Reset enters INIT with sweep counter `cnt`=0.
  - In INIT, each cycle writes 0 to `regs[cnt]` and increments `cnt`. After the write of `cnt`=NREGS-1, the FSM moves to READY.
  - In INIT, `we_i` and `iss_valid_i` are ignored, `rdata_o`=0, and `busy_o`=0.
- **Clear request.** `clr_i` high in READY returns the FSM to INIT with `cnt`=0 and clears all busy bits. `clr_i` high during INIT restarts `cnt` at 0.
- **Writes (READY only).** `regs[waddr_i[p]]` ← `wdata_i[p]` on the edge.
  - If both ports target the same nonzero address, port NWR-1 wins.
  - Each write clears `busy[waddr]`.
- **Scoreboard.** `iss_valid_i` sets `busy[iss_rd_i]`. If the same cycle both sets and clears a register's busy bit, the set wins (new producer).
- **Reads.** Combinational: `rdata_o[p]` = `regs[raddr_i[p]]` and `busy_o[p]` = `busy[raddr_i[p]]`, subject to the bypass macro below.

## Timing
- **Reset values.** `ready_o`=0, `rdata_o`=0, `busy_o`=0, state INIT, `cnt`=0.
- **Sweep length.** INIT lasts exactly NREGS cycles after reset release or after the last `clr_i` cycle. `ready_o` rises in the cycle after the final sweep edge and is registered.
- **Write latency.** A write or issue presented in cycle N is visible to a plain read in cycle N+1.
- **Reset mid-sweep or mid-operation.** Returns immediately to INIT with `cnt`=0 and all busy bits cleared. Array contents are undefined until the sweep completes.
- **No backpressure.** Callers must hold off writes and issues while `ready_o`=0; anything presented then is dropped.

## Configuration
- **`RF_BYPASS_EN` defined.** A read whose address matches an active same-cycle write returns that `wdata_i` (highest matching port). Its `busy_o` shows the cleared value, unless a same-cycle issue to that register sets it. All of this is combinational.
- **`RF_BYPASS_EN` undefined.** Reads return the pre-edge array value and pre-edge busy bit. Writeback-to-read forwarding is then the pipeline's job.

## Structure
- **Shared package `rf_pkg`.** Holds the FSM state enum (`RF_INIT`, `RF_READY`), the default XLEN/NREGS localparams, and the zero-register index constant.
- **Sub-module `rf_clear_seq`.** Contains the INIT/READY FSM, sweep counter, and `ready_o`. It outputs a sweep write enable and address to the array.
- **Top level.** Holds the storage array, write arbitration, scoreboard, and read muxes.

## Test plan
- **Reset and sweep.** Hold `rst_n` low, then release. Expect `ready_o`=0 for 32 cycles, then 1, with every read returning 0. Pulse `rst_n` low at sweep cycle 10 and expect the sweep to restart with 32 full cycles.
- **Write then read.** Write x5=0xDEADBEEF, then read x5 on both ports next cycle: expect 0xDEADBEEF. Write x0=0x1234: x0 still reads 0.
- **Dual-write conflict** (NWR=2). Both ports write x7, with 0x1 on port 0 and 0x2 on port 1. Expect x7=0x2.
- **Scoreboard.** Issue x9: `busy_o`=1 for a read of x9 next cycle. Issue x9 and write x9 in the same cycle: busy stays 1. Write x9 alone: busy is 0 next cycle.
- **Bypass.** With `RF_BYPASS_EN`, write x3=0xAA and read x3 in the same cycle: `rdata_o`=0xAA and busy=0. Without the macro, the old value is returned.
- **Clear request.** Fill x1..x31, pulse `clr_i` in READY. Expect `ready_o`=0 for 32 cycles, then all registers read 0 and all busy bits are 0. A write during the sweep is dropped.
